// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: single-entry holding buffer feeding per-channel shifters.
// SCLK, LRCK and SDOUT are all registered from one free-running frame counter.
module i2s_tx_serializer #(
    parameter int DATA_WIDTH  = 24,
    parameter int SCLK_DIV    = 4,
    parameter int BITS_PER_CH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] tx_data_l,
    input  logic [DATA_WIDTH-1:0] tx_data_r,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  i2s_sclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdout,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int FRAME = SCLK_DIV * 2 * BITS_PER_CH;
    localparam int CW    = $clog2(FRAME);
    localparam int PW    = $clog2(SCLK_DIV);
    localparam int SW    = CW - PW;

    localparam logic [CW-1:0] LAST    = CW'(FRAME - 1);
    localparam logic [PW-1:0] HALF    = PW'(SCLK_DIV / 2);
    localparam logic [SW-1:0] R_SLOT  = SW'(BITS_PER_CH);
    localparam logic [SW-1:0] L_FIRST = SW'(1);
    localparam logic [SW-1:0] L_LAST  = SW'(DATA_WIDTH);
    localparam logic [SW-1:0] R_FIRST = SW'(BITS_PER_CH + 1);
    localparam logic [SW-1:0] R_LAST  = SW'(BITS_PER_CH + DATA_WIDTH);

    logic [CW-1:0]         cnt;
    logic [PW-1:0]         phase;
    logic [SW-1:0]         slot;
    logic                  fall;
    logic                  in_l;
    logic                  in_r;
    logic                  full;
    logic [DATA_WIDTH-1:0] hold_l;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] sh_l;
    logic [DATA_WIDTH-1:0] sh_r;

    // Slot/phase decode; SCLK_DIV is a power of two so these are bit fields.
    assign phase    = cnt[PW-1:0];
    assign slot     = cnt[CW-1:PW];
    assign fall     = (phase == '0);
    assign in_l     = (slot >= L_FIRST) && (slot <= L_LAST);
    assign in_r     = (slot >= R_FIRST) && (slot <= R_LAST);
    assign tx_ready = ~full;

    // Frame counter, pin registers, holding buffer and frame-boundary transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            full        <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            sh_l        <= '0;
            sh_r        <= '0;
            i2s_sclk    <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_sdout   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            cnt         <= (cnt == LAST) ? '0 : cnt + 1'b1;
            i2s_sclk    <= (phase >= HALF);
            i2s_lrck    <= (slot >= R_SLOT);
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (fall) begin
                if (in_l) begin
                    i2s_sdout <= sh_l[DATA_WIDTH-1];
                    sh_l      <= {sh_l[DATA_WIDTH-2:0], 1'b0};
                end else if (in_r) begin
                    i2s_sdout <= sh_r[DATA_WIDTH-1];
                    sh_r      <= {sh_r[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    i2s_sdout <= 1'b0;
                end
            end

            if (tx_valid && !full) begin
                hold_l <= tx_data_l;
                hold_r <= tx_data_r;
                full   <= 1'b1;
            end

            // The last count is never a shift phase, so loading cannot collide.
            if (cnt == LAST) begin
                if (full) begin
                    sh_l        <= hold_l;
                    sh_r        <= hold_r;
                    full        <= 1'b0;
                    frame_start <= 1'b1;
                end else begin
                    sh_l     <= '0;
                    sh_r     <= '0;
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule
